// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - N-to-1 req/gnt/rvalid memory arbiter with in-order response routing
//
// Merges NR_PORTS requesters onto a single memory port. Arbitration is fixed
// priority (ARB_MODE=0, lowest index wins) or round robin (ARB_MODE=1). A
// request that is presented but not granted locks the winner until it is
// granted. Granted port indices are queued in an in-order ID FIFO so that each
// data_rvalid_i is routed back to the issuing port.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   port_*_i / port_gnt_o         per-port request side
//   port_rvalid_o, port_rdata_o   per-port response (rdata broadcast)
//   address_o .. data_req_o       selected request towards memory
//   data_gnt_i, data_rvalid_i,
//   data_rdata_i                  memory handshake and response
//   spurious_o                    rvalid seen with no outstanding request
module mem_req_arbiter #(
    parameter int NR_PORTS        = 3,
    parameter int ADDRESS_SIZE    = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ARB_MODE        = 1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic [NR_PORTS-1:0][ADDRESS_SIZE-1:0]     port_address_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]       port_wdata_i,
    input  logic [NR_PORTS-1:0]                       port_req_i,
    input  logic [NR_PORTS-1:0]                       port_we_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0]     port_be_i,
    output logic [NR_PORTS-1:0]                       port_gnt_o,
    output logic [NR_PORTS-1:0]                       port_rvalid_o,
    output logic [DATA_WIDTH-1:0]                     port_rdata_o,
    output logic [ADDRESS_SIZE-1:0]                   address_o,
    output logic [DATA_WIDTH-1:0]                     data_wdata_o,
    output logic                                      data_we_o,
    output logic [DATA_WIDTH/8-1:0]                   data_be_o,
    output logic                                      data_req_o,
    input  logic                                      data_gnt_i,
    input  logic                                      data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                     data_rdata_i,
    output logic                                      spurious_o
);

    localparam int IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_valid_q, lock_valid_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

    logic [IDX_W-1:0] arb_idx;
    logic             arb_found;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] sel;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Scan order starts at 0 for fixed priority, at rr_ptr for round robin.
    always_comb begin
        int cand;
        arb_idx   = '0;
        arb_found = 1'b0;
        cand      = 0;
        for (int i = 0; i < NR_PORTS; i++) begin
            if (ARB_MODE == 0) begin
                cand = i;
            end else begin
                cand = (int'(rr_ptr_q) + i) % NR_PORTS;
            end
            if (!arb_found && port_req_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'(cand);
            end
        end
    end

    // A stalled request keeps its port on the bus until granted.
    assign winner     = lock_valid_q ? lock_idx_q : arb_idx;
    assign full       = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty      = (count_q == '0);
    assign data_req_o = !full && (lock_valid_q || arb_found);
    assign push       = data_req_o && data_gnt_i;
    assign pop        = data_rvalid_i && !empty;
    assign spurious_o = data_rvalid_i && empty;

    assign sel          = data_req_o ? winner : '0;
    assign address_o    = port_address_i[sel];
    assign data_wdata_o = port_wdata_i[sel];
    assign data_we_o    = port_we_i[sel];
    assign data_be_o    = port_be_i[sel];
    assign port_rdata_o = data_rdata_i;

    always_comb begin
        port_gnt_o    = '0;
        port_rvalid_o = '0;
        if (push) begin
            port_gnt_o[winner] = 1'b1;
        end
        if (pop) begin
            port_rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rr_ptr_d     = rr_ptr_q;
        lock_valid_d = lock_valid_q;
        lock_idx_d   = lock_idx_q;

        if (push) begin
            wr_ptr_d     = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
            lock_valid_d = 1'b0;
            if (ARB_MODE == 1) begin
                rr_ptr_d = (winner == IDX_W'(NR_PORTS - 1)) ? '0 : winner + 1'b1;
            end
        end else if (data_req_o) begin
            lock_valid_d = 1'b1;
            lock_idx_d   = winner;
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rr_ptr_q     <= '0;
            lock_valid_q <= 1'b0;
            lock_idx_q   <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_valid_q <= lock_valid_d;
            lock_idx_q   <= lock_idx_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= winner;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - scoreboard bench for mem_req_arbiter (round-robin and fixed-priority instances)
module tb_mem_req_arbiter;

    localparam int N   = 3;
    localparam int MAX = 4;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [N-1:0][63:0] port_address_i;
    logic [N-1:0][63:0] port_wdata_i;
    logic [N-1:0]       port_req_i;
    logic [N-1:0]       port_we_i;
    logic [N-1:0][7:0]  port_be_i;
    logic            data_gnt_i;
    logic            data_rvalid_i;
    logic [63:0]     data_rdata_i;

    logic [N-1:0] rr_gnt, rr_rvalid, fp_gnt, fp_rvalid;
    logic [63:0]  rr_rdata, fp_rdata, rr_addr, fp_addr, rr_wdata, fp_wdata;
    logic         rr_we, fp_we, rr_req, fp_req, rr_spur, fp_spur;
    logic [7:0]   rr_be, fp_be;

    always #5 clk = ~clk;

    mem_req_arbiter #(.NR_PORTS(N), .MAX_OUTSTANDING(MAX), .ARB_MODE(1)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .port_address_i(port_address_i), .port_wdata_i(port_wdata_i),
        .port_req_i(port_req_i), .port_we_i(port_we_i), .port_be_i(port_be_i),
        .port_gnt_o(rr_gnt), .port_rvalid_o(rr_rvalid), .port_rdata_o(rr_rdata),
        .address_o(rr_addr), .data_wdata_o(rr_wdata), .data_we_o(rr_we), .data_be_o(rr_be),
        .data_req_o(rr_req), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i), .spurious_o(rr_spur)
    );

    mem_req_arbiter #(.NR_PORTS(N), .MAX_OUTSTANDING(MAX), .ARB_MODE(0)) dut_fp (
        .clk_i(clk), .rst_ni(rst_ni),
        .port_address_i(port_address_i), .port_wdata_i(port_wdata_i),
        .port_req_i(port_req_i), .port_we_i(port_we_i), .port_be_i(port_be_i),
        .port_gnt_o(fp_gnt), .port_rvalid_o(fp_rvalid), .port_rdata_o(fp_rdata),
        .address_o(fp_addr), .data_wdata_o(fp_wdata), .data_we_o(fp_we), .data_be_o(fp_be),
        .data_req_o(fp_req), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i), .spurious_o(fp_spur)
    );

    typedef struct {
        int          cyc;
        bit          req;
        logic [63:0] addr;
        logic [63:0] wd;
        bit          we;
        logic [7:0]  be;
    } cyc_t;

    typedef struct {
        int          cyc;
        int          rr;
        int          fp;
        logic [63:0] d;
    } ev_t;

    typedef struct {
        int rr;
        int fp;
    } id_t;

    cyc_t cq[$];
    ev_t  gq[$];
    ev_t  rq[$];
    int   sq[$];

    // Reference state: outstanding IDs in issue order, lock per instance, rr pointer
    id_t oq[$];
    int  lock_rr, lock_fp, rr_ptr;
    bit  pend [N];
    int  cur_cyc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cur_cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] onehot(input int p);
        logic [63:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    task automatic step(input int preq, input int pgnt, input int prv, input bit do_rst);
        cyc_t c;
        ev_t  e;
        id_t  id;
        int   w_rr, w_fp, p;
        bit   req, grant;
        cur_cyc++;
        rst_ni = !do_rst;
        for (int i = 0; i < N; i++) begin
            if (do_rst) begin
                pend[i] = 1'b0;
            end else if (!pend[i] && $urandom_range(99) < preq) begin
                pend[i]           = 1'b1;
                port_address_i[i] = {$urandom, $urandom};
                port_wdata_i[i]   = {$urandom, $urandom};
                port_we_i[i]      = $urandom_range(1);
                port_be_i[i]      = 8'($urandom);
            end
            port_req_i[i] = pend[i];
        end
        data_gnt_i    = !do_rst && ($urandom_range(99) < pgnt);
        data_rvalid_i = !do_rst && ($urandom_range(99) < prv);
        data_rdata_i  = {$urandom, $urandom};
        if (do_rst) begin
            oq.delete();
            lock_rr = -1;
            lock_fp = -1;
            rr_ptr  = 0;
        end

        // Winners from the arbitration rules
        w_rr = lock_rr;
        w_fp = lock_fp;
        if (lock_rr < 0) begin
            for (int k = N - 1; k >= 0; k--) begin
                p = (rr_ptr + k) % N;
                if (port_req_i[p]) w_rr = p;
            end
        end
        if (lock_fp < 0) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (port_req_i[k]) w_fp = k;
            end
        end
        req   = (oq.size() < MAX) && (w_rr >= 0);
        grant = req && data_gnt_i;

        c.cyc  = cur_cyc;
        c.req  = req;
        p      = req ? w_rr : 0;
        c.addr = port_address_i[p];
        c.wd   = port_wdata_i[p];
        c.we   = port_we_i[p];
        c.be   = port_be_i[p];
        cq.push_back(c);

        if (data_rvalid_i) begin
            if (oq.size() > 0) begin
                id    = oq.pop_front();
                e.cyc = cur_cyc;
                e.rr  = id.rr;
                e.fp  = id.fp;
                e.d   = data_rdata_i;
                rq.push_back(e);
            end else begin
                sq.push_back(cur_cyc);
            end
        end

        if (grant) begin
            e.cyc = cur_cyc;
            e.rr  = w_rr;
            e.fp  = w_fp;
            e.d   = '0;
            gq.push_back(e);
            id.rr = w_rr;
            id.fp = w_fp;
            oq.push_back(id);
            rr_ptr       = (w_rr + 1) % N;
            lock_rr      = -1;
            lock_fp      = -1;
            pend[w_rr]   = 1'b0;
        end else if (req) begin
            lock_rr = w_rr;
            lock_fp = w_fp;
        end
    endtask

    // Monitor: pops expectations whenever the DUTs present an event
    always @(negedge clk) begin
        cyc_t c;
        ev_t  e;
        int   s;
        if (cq.size() == 0) begin
            chk("cycle_queue_empty", 64'd1, 64'd0);
        end else begin
            c = cq.pop_front();
            chk("data_req_rr", 64'(rr_req), 64'(c.req));
            chk("data_req_fp", 64'(fp_req), 64'(c.req));
            chk("address", rr_addr, c.addr);
            chk("wdata", rr_wdata, c.wd);
            chk("we", 64'(rr_we), 64'(c.we));
            chk("be", 64'(rr_be), 64'(c.be));
        end
        if (|rr_gnt || |fp_gnt) begin
            if (gq.size() == 0) begin
                chk("unexpected_gnt", 64'({fp_gnt, rr_gnt}), 64'd0);
            end else begin
                e = gq.pop_front();
                chk("gnt_cycle", 64'(cur_cyc), 64'(e.cyc));
                chk("gnt_rr", 64'(rr_gnt), onehot(e.rr));
                chk("gnt_fp", 64'(fp_gnt), onehot(e.fp));
            end
        end
        if (|rr_rvalid || |fp_rvalid) begin
            if (rq.size() == 0) begin
                chk("unexpected_rvalid", 64'({fp_rvalid, rr_rvalid}), 64'd0);
            end else begin
                e = rq.pop_front();
                chk("rvalid_cycle", 64'(cur_cyc), 64'(e.cyc));
                chk("rvalid_rr", 64'(rr_rvalid), onehot(e.rr));
                chk("rvalid_fp", 64'(fp_rvalid), onehot(e.fp));
                chk("rdata", rr_rdata, e.d);
                chk("rdata_fp", fp_rdata, e.d);
            end
        end
        if (rr_spur || fp_spur) begin
            if (sq.size() == 0) begin
                chk("unexpected_spurious", 64'({fp_spur, rr_spur}), 64'd0);
            end else begin
                s = sq.pop_front();
                chk("spurious_cycle", 64'(cur_cyc), 64'(s));
                chk("spurious_both", 64'({fp_spur, rr_spur}), 64'd3);
            end
        end
    end

    initial begin
        rst_ni         = 1'b0;
        port_address_i = '0;
        port_wdata_i   = '0;
        port_req_i     = '0;
        port_we_i      = '0;
        port_be_i      = '0;
        data_gnt_i     = 1'b0;
        data_rvalid_i  = 1'b0;
        data_rdata_i   = '0;
        lock_rr        = -1;
        lock_fp        = -1;
        rr_ptr         = 0;
        cur_cyc        = 0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;

        repeat (2) begin @(posedge clk); #1; step(0, 0, 0, 1); end
        // All ports requesting, granted every cycle, responses following
        repeat (8) begin @(posedge clk); #1; step(100, 100, 100, 0); end
        // Fill the ID FIFO, then one pop reopens it
        repeat (6) begin @(posedge clk); #1; step(100, 100, 0, 0); end
        @(posedge clk); #1; step(100, 0, 100, 0);
        repeat (2) begin @(posedge clk); #1; step(100, 100, 0, 0); end
        repeat (6) begin @(posedge clk); #1; step(0, 0, 100, 0); end
        // Stalled grants hold the lock
        repeat (4) begin @(posedge clk); #1; step(100, 0, 0, 0); end
        @(posedge clk); #1; step(100, 100, 0, 0);
        // Random traffic
        repeat (3000) begin @(posedge clk); #1; step(40, 60, 45, 0); end
        repeat (6) begin @(posedge clk); #1; step(0, 0, 100, 0); end
        // Reset with outstanding IDs, then responses arrive and are spurious
        repeat (2) begin @(posedge clk); #1; step(100, 100, 0, 0); end
        @(posedge clk); #1; step(0, 0, 0, 1);
        repeat (3) begin @(posedge clk); #1; step(0, 0, 100, 0); end

        @(negedge clk); #1;
        chk("leftover_cycles", 64'(cq.size()), 64'd0);
        chk("leftover_grants", 64'(gq.size()), 64'd0);
        chk("leftover_responses", 64'(rq.size()), 64'd0);
        chk("leftover_spurious", 64'(sq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
